// File: rtl/jc_phase_sequencer_if.sv
// Handshake/control bundle for the Johnson phase sequencer.
// JC_PAUSE_EN adds the pause control line.
interface jc_phase_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 8,
  parameter int IDX_W = 3
);
  logic             start;
  logic             stop;
  logic             mode;
  logic [DIV_W-1:0] dwell;
`ifdef JC_PAUSE_EN
  logic             pause;
`endif
  logic [WIDTH-1:0] q;
  logic [IDX_W-1:0] phase_idx;
  logic             step;
  logic             busy;
  logic             done;

`ifdef JC_PAUSE_EN
  modport master (
    output start, stop, mode, dwell, pause,
    input  q, phase_idx, step, busy, done
  );
  modport slave (
    input  start, stop, mode, dwell, pause,
    output q, phase_idx, step, busy, done
  );
`else
  modport master (
    output start, stop, mode, dwell,
    input  q, phase_idx, step, busy, done
  );
  modport slave (
    input  start, stop, mode, dwell,
    output q, phase_idx, step, busy, done
  );
`endif
endinterface

// File: rtl/jc_phase_sequencer.sv
// Johnson-counter phase sequencer with programmable dwell per phase.
// Optional JC_PAUSE_EN macro adds a pause input that freezes the run.
module jc_phase_sequencer #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 8,
  parameter int IDX_W = 3
) (
  input  logic clk,
  input  logic rst,
  jc_phase_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(2 * WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] q_r, q_n;
  logic [IDX_W-1:0] idx_r, idx_n;
  logic [DIV_W-1:0] cnt_r, cnt_n;
  logic [DIV_W-1:0] dwl_r, dwl_n;
  logic             mode_r, mode_n;
  logic             pend_r, pend_n;
  logic             step_r, step_n;
  logic             busy_r, busy_n;
  logic             done_r, done_n;
  logic             hold;

`ifdef JC_PAUSE_EN
  assign hold = bus.pause;
`else
  assign hold = 1'b0;
`endif

  // State register; reset forces IDLE regardless of other inputs
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Registered datapath and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= '0;
      idx_r  <= '0;
      cnt_r  <= '0;
      dwl_r  <= '0;
      mode_r <= 1'b0;
      pend_r <= 1'b0;
      step_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      q_r    <= q_n;
      idx_r  <= idx_n;
      cnt_r  <= cnt_n;
      dwl_r  <= dwl_n;
      mode_r <= mode_n;
      pend_r <= pend_n;
      step_r <= step_n;
      busy_r <= busy_n;
      done_r <= done_n;
    end
  end

  // Next-state, dwell countdown and phase advance
  always_comb begin
    state_n = state;
    q_n     = q_r;
    idx_n   = idx_r;
    cnt_n   = cnt_r;
    dwl_n   = dwl_r;
    mode_n  = mode_r;
    pend_n  = pend_r;
    step_n  = 1'b0;
    busy_n  = busy_r;
    done_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        q_n    = '0;
        idx_n  = '0;
        busy_n = 1'b0;
        pend_n = 1'b0;
        if (bus.start && !bus.stop) begin
          mode_n  = bus.mode;
          dwl_n   = bus.dwell;
          cnt_n   = bus.dwell;
          busy_n  = 1'b1;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        busy_n = 1'b1;
        pend_n = pend_r | bus.stop;
        priority case (1'b1)
          hold: begin
          end
          (cnt_r != '0): begin
            cnt_n = cnt_r - DIV_W'(1);
          end
          default: begin
            q_n    = {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
            idx_n  = (idx_r == LAST) ? '0
                   : idx_r + IDX_W'(1);
            cnt_n  = dwl_r;
            step_n = 1'b1;
            if (idx_r == LAST && (mode_r || pend_r)) begin
              done_n  = 1'b1;
              state_n = S_DONE;
            end
          end
        endcase
      end
      S_DONE: begin
        q_n     = '0;
        idx_n   = '0;
        busy_n  = 1'b0;
        pend_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: begin
        q_n     = '0;
        idx_n   = '0;
        busy_n  = 1'b0;
        pend_n  = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.q         = q_r;
  assign bus.phase_idx = idx_r;
  assign bus.step      = step_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_jc_phase_sequencer.sv
// Self-checking bench for jc_phase_sequencer: vector table,
// directed corner sequences and randomized run against a phase model.
module tb_jc_phase_sequencer;

  localparam int W  = 4;
  localparam int DW = 8;
  localparam int IW = 3;
  localparam int NP = 2 * W;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  jc_phase_sequencer_if #(.WIDTH(W), .DIV_W(DW), .IDX_W(IW)) bus ();

  jc_phase_sequencer #(.WIDTH(W), .DIV_W(DW), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: phase number plus cycles spent in that phase
  int m_st;      // 0 idle, 1 running, 2 finishing
  int m_idx;
  int m_age;
  int m_dwell;
  int m_mode;
  int m_stop;
  int m_step;
  int m_busy;
  int m_done;

  function automatic logic [W-1:0] jc(input int k);
    if (k <= W) return W'((1 << k) - 1);
    return W'(((1 << W) - 1) << (k - W));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, s, p, m,
                            input int d, input logic pz);
    int old_stop;
    m_step = 0;
    m_done = 0;
    if (r) begin
      m_st = 0; m_idx = 0; m_age = 0; m_busy = 0; m_stop = 0;
      return;
    end
    case (m_st)
      0: begin
        m_idx = 0;
        m_busy = 0;
        m_stop = 0;
        if (s && !p) begin
          m_st = 1; m_dwell = d; m_mode = m; m_age = 0; m_busy = 1;
        end
      end
      1: begin
        old_stop = m_stop;
        if (p) m_stop = 1;
        if (!pz) begin
          if (m_age == m_dwell) begin
            m_age = 0;
            m_idx = (m_idx + 1) % NP;
            m_step = 1;
            if (m_idx == 0 && (m_mode == 1 || old_stop == 1)) begin
              m_st = 2;
              m_done = 1;
            end
          end else begin
            m_age++;
          end
        end
      end
      default: begin
        m_st = 0; m_idx = 0; m_busy = 0; m_stop = 0;
      end
    endcase
  endtask

  // apply one cycle of inputs, advance the model, compare all outputs
  task automatic tick(input logic r, s, p, m,
                      input int d, input logic pz);
    rst = r;
    bus.start = s;
    bus.stop  = p;
    bus.mode  = m;
    bus.dwell = DW'(d);
`ifdef JC_PAUSE_EN
    bus.pause = pz;
`endif
    @(posedge clk);
    model_step(r, s, p, m, d, pz);
    #1;
    chk("q", int'(bus.q), int'(jc(m_idx)));
    chk("phase_idx", int'(bus.phase_idx), m_idx);
    chk("step", int'(bus.step), m_step);
    chk("busy", int'(bus.busy), m_busy);
    chk("done", int'(bus.done), m_done);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  typedef struct {
    logic       rst, start, stop, mode;
    int         dwell;
    logic [3:0] q;
    int         idx;
    logic       step, busy, done;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(logic r, s, p, m, int d,
                              logic [3:0] q, int i,
                              logic st, b, dn);
    vec_t v;
    v.rst = r; v.start = s; v.stop = p; v.mode = m; v.dwell = d;
    v.q = q; v.idx = i; v.step = st; v.busy = b; v.done = dn;
    return v;
  endfunction

  initial begin
    int n, steps, dones;
    bit seen;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.mode  = 1'b0;
    bus.dwell = '0;
`ifdef JC_PAUSE_EN
    bus.pause = 1'b0;
`endif
    m_st = 0; m_idx = 0; m_age = 0; m_dwell = 0;
    m_mode = 0; m_stop = 0; m_step = 0; m_busy = 0; m_done = 0;

    // single pass, dwell 0, then start+stop in idle
    vt[0]  = mk(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    vt[1]  = mk(0, 1, 0, 1, 0, 4'b0000, 0, 0, 1, 0);
    vt[2]  = mk(0, 0, 0, 0, 5, 4'b0001, 1, 1, 1, 0);
    vt[3]  = mk(0, 0, 0, 0, 5, 4'b0011, 2, 1, 1, 0);
    vt[4]  = mk(0, 0, 0, 0, 5, 4'b0111, 3, 1, 1, 0);
    vt[5]  = mk(0, 0, 0, 0, 5, 4'b1111, 4, 1, 1, 0);
    vt[6]  = mk(0, 0, 0, 0, 5, 4'b1110, 5, 1, 1, 0);
    vt[7]  = mk(0, 0, 0, 0, 5, 4'b1100, 6, 1, 1, 0);
    vt[8]  = mk(0, 0, 0, 0, 5, 4'b1000, 7, 1, 1, 0);
    vt[9]  = mk(0, 0, 0, 0, 5, 4'b0000, 0, 1, 1, 1);
    vt[10] = mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    vt[11] = mk(0, 1, 1, 1, 0, 4'b0000, 0, 0, 0, 0);
    vt[12] = mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      tick(vt[i].rst, vt[i].start, vt[i].stop, vt[i].mode,
           vt[i].dwell, 1'b0);
      chk($sformatf("vec%0d_q", i), int'(bus.q), int'(vt[i].q));
      chk($sformatf("vec%0d_idx", i), int'(bus.phase_idx), vt[i].idx);
      chk($sformatf("vec%0d_step", i), int'(bus.step), int'(vt[i].step));
      chk($sformatf("vec%0d_busy", i), int'(bus.busy), int'(vt[i].busy));
      chk($sformatf("vec%0d_done", i), int'(bus.done), int'(vt[i].done));
    end

    // dwell 2 single pass: 24 running cycles, 8 steps
    tick(0, 1, 0, 1, 2, 0);
    n = 0; steps = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      idle();
      n++;
      if (bus.step) steps++;
      if (bus.done) seen = 1;
    end
    chk("t2_done_seen", int'(seen), 1);
    chk("t2_run_cycles", n, 24);
    chk("t2_steps", steps, 8);
    idle();
    chk("t2_busy_after", int'(bus.busy), 0);

    // continuous with stop at idx 3
    tick(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 20 && bus.phase_idx != 3; i++) idle();
    tick(0, 0, 1, 0, 0, 0);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      idle();
      if (bus.done) seen = 1;
    end
    chk("t3_stop_done", int'(seen), 1);
    chk("t3_done_q", int'(bus.q), 0);
    idle();
    chk("t3_idle_busy", int'(bus.busy), 0);

    // continuous without stop: five wraps, no done
    tick(0, 1, 0, 0, 1, 0);
    dones = 0;
    for (int i = 0; i < 5 * NP * 2 + 3; i++) begin
      idle();
      if (bus.done) dones++;
    end
    chk("t3_no_done", dones, 0);
    chk("t3_still_busy", int'(bus.busy), 1);

    // reset at idx 5 aborts without done
    for (int i = 0; i < 20 && bus.phase_idx != 5; i++) idle();
    chk("t4_at_idx5", int'(bus.phase_idx), 5);
    tick(1, 0, 0, 0, 0, 0);
    chk("t4_q", int'(bus.q), 0);
    chk("t4_busy", int'(bus.busy), 0);
    chk("t4_done", int'(bus.done), 0);
    idle();

    // restart while running is ignored
    tick(0, 1, 0, 1, 1, 0);
    n = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (i == 2) tick(0, 1, 0, 0, 7, 0);
      else idle();
      n++;
      if (bus.done) seen = 1;
    end
    chk("t5_done_seen", int'(seen), 1);
    chk("t5_run_cycles", n, 16);
    idle();

`ifdef JC_PAUSE_EN
    // pause at idx 2 holds q for ten cycles
    tick(0, 1, 0, 1, 0, 0);
    idle();
    idle();
    chk("t6_at_idx2", int'(bus.q), 3);
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 0, 0, 1);
      chk("t6_hold_q", int'(bus.q), 3);
      chk("t6_hold_step", int'(bus.step), 0);
    end
    idle();
    chk("t6_resume_q", int'(bus.q), 7);
    for (int i = 0; i < 12; i++) idle();
`endif

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic r, s, p, m, pz;
      int d;
      r  = ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 9) == 0);
      p  = ($urandom_range(0, 39) == 0);
      m  = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255)
                                       : $urandom_range(0, 3);
      pz = 1'b0;
`ifdef JC_PAUSE_EN
      pz = ($urandom_range(0, 7) == 0);
`endif
      tick(r, s, p, m, d, pz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
